key_debounce_latch: RTL and testbench
=====================================

// Module: key_debounce_latch
// PURPOSE
//  Front end for the 8-input encoder: synchronises and debounces 8 raw switch/key lines.
//  Detects press (0->1) events and latches the pressed key as a one-hot vector.
//  key_oh[7:0] drives the encoder inputs i0..i7. Bit k of key_oh feeds input ik.
//  The latched key is held for the consumer until it is acknowledged with key_ack.
// PARAMETERS
//  DEBOUNCE_CYC  4     consecutive synchronised cycles a new level must persist before acceptance (>=2)
//  CNT_W         $clog2(DEBOUNCE_CYC)  width of each per-channel debounce counter (derived, not overridden)
// PORTS
//  clk         in   1  single system clock, all logic rising-edge
//  rst_n       in   1  synchronous, active-low reset
//  key_in      in   8  raw asynchronous key levels, 1 = pressed
//  key_ack     in   1  consumer has taken key_oh; single-cycle pulse
//  clear       in   1  drop any held key and clear overrun; single-cycle pulse
//  key_oh      out  8  latched pressed key, one-hot or all-zero
//  key_valid   out  1  key_oh holds an unacknowledged key
//  key_stable  out  8  debounced level of each channel
//  overrun     out  1  sticky: a press was lost while a key was held
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all of the following are cleared to 0, and the FSM goes to IDLE:
//   - sync flops, counters, key_stable
//   - key_oh, key_valid, overrun
//  - Reset mid-debounce aborts the debounce; a key held through reset is re-detected as a new press.
//  Sync: 2-flop synchroniser per bit (s1 -> s2).
//  Debounce, per channel k:
//   - s2[k]==key_stable[k]: cnt[k]<=0.
//   - Else, cnt[k]==DEBOUNCE_CYC-1: key_stable[k]<=s2[k] and cnt[k]<=0.
//   - Else: cnt[k]<=cnt[k]+1.
//   - A disagreement shorter than DEBOUNCE_CYC cycles is ignored; release is debounced identically.
//  Press event:
//   - rise[k] = key_stable[k] updates 0->1, i.e. the accepting update itself.
//   - rise[k] is registered once into a 1-cycle press vector.
//   - Several simultaneous rises: the highest index wins, matching encoder priority (i7 highest).
//   - Releases are never reported.
//  Latency: key_in held 1 from the first edge that samples it high (edge 1) ->
//   - key_stable rises at edge DEBOUNCE_CYC+2;
//   - key_valid/key_oh update at edge DEBOUNCE_CYC+3.
//  FSM IDLE / HOLD:
//   - IDLE, press: key_oh<=onehot(winner), key_valid<=1 -> HOLD.
//   - HOLD, key_ack only: key_oh<=0, key_valid<=0 -> IDLE.
//   - HOLD, press without ack: key_oh unchanged, overrun<=1 (sticky), stay HOLD.
//   - HOLD, ack and press same cycle: old key consumed, key_oh<=new one-hot, key_valid stays 1, overrun unchanged.
//   - IDLE, key_ack: ignored.
//  clear (highest priority after reset):
//   - key_oh<=0, key_valid<=0, overrun<=0 -> IDLE.
//   - A press in the same cycle is discarded.
//   - Debounce state is untouched.
//  key_oh is never multi-hot. key_valid==1 <=> key_oh!=0. All outputs are registered.
// TESTING (DEBOUNCE_CYC=4)
//  1. key_in=8'h04 held from edge 1 -> key_stable=8'h04 at edge 6; key_valid=1, key_oh=8'h04 at edge 7; key_ack pulse -> next edge key_valid=0, key_oh=0.
//  2. key_in[3] high for 3 cycles then low -> key_stable, key_valid and key_oh stay 0 throughout.
//  3. key_in 8'h00->8'h81 in one cycle -> key_oh=8'h80, key_valid=1 at edge 7, overrun=0.
//  4. key 2 held/latched, no ack, then key_in[5] rises -> key_oh stays 8'h04, overrun=1; clear pulse -> key_valid=0, key_oh=0, overrun=0.
//  5. HOLD with 8'h02, key_ack in the same cycle as press of key 6 -> key_oh=8'h40, key_valid stays 1, overrun=0.
//  6. key_in=8'h10 stable, rst_n=0 at edge 3 (mid-debounce), released at edge 5, key held -> key_valid=1, key_oh=8'h10 at edge 12.

Source files
------------

// File: rtl/key_debounce_latch_if.sv
// Key front-end bundle: raw keys and consumer controls in,
// debounced levels and the latched one-hot key out.
interface key_debounce_latch_if;
    logic [7:0] key_in;
    logic       key_ack;
    logic       clear;
    logic [7:0] key_oh;
    logic       key_valid;
    logic [7:0] key_stable;
    logic       overrun;

    modport master (
        output key_in,
        output key_ack,
        output clear,
        input  key_oh,
        input  key_valid,
        input  key_stable,
        input  overrun
    );

    modport slave (
        input  key_in,
        input  key_ack,
        input  clear,
        output key_oh,
        output key_valid,
        output key_stable,
        output overrun
    );
endinterface

// File: rtl/key_debounce_latch.sv
// Synchronises, debounces and latches presses on 8 key lines.
// The latched key is one-hot, highest index wins, held until acked.
module key_debounce_latch #(
    parameter  int DEBOUNCE_CYC = 4,
    localparam int CNT_W        = $clog2(DEBOUNCE_CYC)
) (
    input logic                 clk,
    input logic                 rst_n,
    key_debounce_latch_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    logic [7:0]       s1_q;
    logic [7:0]       s2_q;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [7:0]       stable_q;
    logic [7:0]       stable_d;
    logic [7:0]       rise;
    logic [7:0]       press_d;
    logic [7:0]       press_q;
    state_t           state_q;
    logic [7:0]       key_oh_q;
    logic             key_valid_q;
    logic             overrun_q;

    // Per-channel debounce counters and rise detection on acceptance.
    always_comb begin
        stable_d = stable_q;
        for (int k = 0; k < 8; k++) begin
            cnt_d[k] = cnt_q[k];
            if (s2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                stable_d[k] = s2_q[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
        end
        rise = stable_d & ~stable_q;
    end

    // Reduce simultaneous rises to one-hot; later (higher) index wins.
    always_comb begin
        press_d = '0;
        for (int k = 0; k < 8; k++) begin
            if (rise[k]) begin
                press_d    = '0;
                press_d[k] = 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and one-cycle press vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            press_q  <= '0;
            for (int k = 0; k < 8; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            s1_q     <= bus.key_in;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int k = 0; k < 8; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Hold FSM: latch a press, release on ack, flag lost presses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_oh_q    <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (bus.clear) begin
            state_q     <= IDLE;
            key_oh_q    <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|press_q) begin
                        key_oh_q    <= press_q;
                        key_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (|press_q) begin
                        if (bus.key_ack) begin
                            key_oh_q <= press_q;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (bus.key_ack) begin
                        key_oh_q    <= '0;
                        key_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.key_oh     = key_oh_q;
    assign bus.key_valid  = key_valid_q;
    assign bus.key_stable = stable_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_key_debounce_latch.sv
// Scoreboard bench: stimulus queues expected output tuples with
// their edge number; a negedge monitor pops one per output change.
module tb_key_debounce_latch;

    typedef struct {
        int unsigned e;
        logic [7:0]  st;
        logic [7:0]  oh;
        logic        v;
        logic        ov;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int unsigned base;
    int unsigned b2;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    ev_t         exp_q[$];

    key_debounce_latch_if kif ();

    key_debounce_latch #(.DEBOUNCE_CYC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned e, input logic [7:0] st,
                        input logic [7:0] oh, input logic v,
                        input logic ov);
        ev_t x;
        x.e  = e;
        x.st = st;
        x.oh = oh;
        x.v  = v;
        x.ov = ov;
        exp_q.push_back(x);
    endtask

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic ack_pulse();
        kif.key_ack = 1'b1;
        step(1);
        kif.key_ack = 1'b0;
    endtask

    // Monitor: any change of the output tuple must match the next
    // queued event, both in value and in the edge it appeared on.
    logic [17:0] prev;
    logic [17:0] cur;
    ev_t         got;
    always @(negedge clk) begin
        cur = {kif.key_stable, kif.key_oh, kif.key_valid, kif.overrun};
        if (!mon_en) begin
            prev = cur;
        end else if (cur !== prev) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change @edge %0d: st=%h oh=%h v=%b ov=%b",
                         cyc, cur[17:10], cur[9:2], cur[1], cur[0]);
            end else begin
                got = exp_q.pop_front();
                if (cyc != got.e || cur !== {got.st, got.oh, got.v, got.ov}) begin
                    n_fail++;
                    $display("FAIL event: got edge %0d st=%h oh=%h v=%b ov=%b, expected edge %0d st=%h oh=%h v=%b ov=%b",
                             cyc, cur[17:10], cur[9:2], cur[1], cur[0],
                             got.e, got.st, got.oh, got.v, got.ov);
                end
            end
            prev = cur;
        end
    end

    initial begin
        rst_n       = 1'b0;
        kif.key_in  = 8'h00;
        kif.key_ack = 1'b0;
        kif.clear   = 1'b0;
        step(3);
        check("rst_key_stable", kif.key_stable, 8'h00);
        check("rst_key_oh", kif.key_oh, 8'h00);
        check("rst_key_valid", {7'd0, kif.key_valid}, 8'h00);
        check("rst_overrun", {7'd0, kif.overrun}, 8'h00);
        rst_n = 1'b1;
        step(1);
        mon_en = 1'b1;
        step(1);

        // 1: single press, ack, release
        base = cyc;
        kif.key_in = 8'h04;
        push(base + 6, 8'h04, 8'h00, 1'b0, 1'b0);
        push(base + 7, 8'h04, 8'h04, 1'b1, 1'b0);
        step(8);
        push(base + 9, 8'h04, 8'h00, 1'b0, 1'b0);
        ack_pulse();
        step(1);
        kif.key_in = 8'h00;
        push(base + 16, 8'h00, 8'h00, 1'b0, 1'b0);
        step(10);

        // 2: 3-cycle glitch ignored; ack and clear in IDLE ignored
        kif.key_in = 8'h08;
        step(3);
        kif.key_in = 8'h00;
        step(2);
        ack_pulse();
        kif.clear = 1'b1;
        step(1);
        kif.clear = 1'b0;
        step(8);

        // 3: simultaneous rise of 0 and 7, highest wins
        base = cyc;
        kif.key_in = 8'h81;
        push(base + 6, 8'h81, 8'h00, 1'b0, 1'b0);
        push(base + 7, 8'h81, 8'h80, 1'b1, 1'b0);
        step(8);
        push(base + 9, 8'h81, 8'h00, 1'b0, 1'b0);
        ack_pulse();
        step(1);
        kif.key_in = 8'h00;
        push(base + 16, 8'h00, 8'h00, 1'b0, 1'b0);
        step(10);

        // 4: overrun while held, then clear
        base = cyc;
        kif.key_in = 8'h04;
        push(base + 6, 8'h04, 8'h00, 1'b0, 1'b0);
        push(base + 7, 8'h04, 8'h04, 1'b1, 1'b0);
        step(8);
        kif.key_in = 8'h24;
        push(base + 14, 8'h24, 8'h04, 1'b1, 1'b0);
        push(base + 15, 8'h24, 8'h04, 1'b1, 1'b1);
        step(8);
        kif.clear = 1'b1;
        push(base + 17, 8'h24, 8'h00, 1'b0, 1'b0);
        step(1);
        kif.clear = 1'b0;
        step(1);
        kif.key_in = 8'h00;
        push(base + 24, 8'h00, 8'h00, 1'b0, 1'b0);
        step(10);

        // 5: ack coincident with new press replaces key
        base = cyc;
        kif.key_in = 8'h02;
        push(base + 6, 8'h02, 8'h00, 1'b0, 1'b0);
        push(base + 7, 8'h02, 8'h02, 1'b1, 1'b0);
        step(8);
        b2 = cyc;
        kif.key_in = 8'h42;
        push(b2 + 6, 8'h42, 8'h02, 1'b1, 1'b0);
        push(b2 + 7, 8'h42, 8'h40, 1'b1, 1'b0);
        step(6);
        ack_pulse();
        step(1);
        push(b2 + 9, 8'h42, 8'h00, 1'b0, 1'b0);
        ack_pulse();
        step(1);
        kif.key_in = 8'h00;
        push(b2 + 16, 8'h00, 8'h00, 1'b0, 1'b0);
        step(10);

        // 6: reset mid-debounce, key re-detected after release
        base = cyc;
        kif.key_in = 8'h10;
        step(2);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        push(base + 11, 8'h10, 8'h00, 1'b0, 1'b0);
        push(base + 12, 8'h10, 8'h10, 1'b1, 1'b0);
        step(8);
        push(base + 14, 8'h10, 8'h00, 1'b0, 1'b0);
        ack_pulse();
        step(1);
        kif.key_in = 8'h00;
        push(base + 21, 8'h00, 8'h00, 1'b0, 1'b0);
        step(10);

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d left, expected 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
